// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared fetch-pipeline widths, exception bit indices and entry layout
package inst_fetch_queue_pkg;

  localparam int IFQ_PC_W    = 32;
  localparam int IFQ_INSTR_W = 32;
  localparam int IFQ_EXC_W   = 8;

  // Fetch exception vector bit positions
  localparam int ADEL_IF = 7;

  typedef struct packed {
    logic [IFQ_PC_W-1:0]    pc;
    logic [IFQ_INSTR_W-1:0] instr;
    logic [IFQ_EXC_W-1:0]   exc;
  } fetchEntry_t;

  function automatic int entryWidth(input int pcW, input int instrW, input int excW);
    return pcW + instrW + excW;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo_ram_2p.sv
// rtl/inst_fetch_queue_fifo_ram_2p.sv - DEPTH x WIDTH storage, one write port, one asynchronous read port
module fifo_ram_2p #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 72,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - credit-based instruction fetch queue with flush annulment of in-flight responses
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int INSTR_W = IFQ_INSTR_W,
  parameter  int PC_W    = IFQ_PC_W,
  parameter  int EXC_W   = IFQ_EXC_W,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               req_allow,
  input  logic               req_issue,
  input  logic               resp_valid,
  input  logic [INSTR_W-1:0] resp_instr,
  input  logic [PC_W-1:0]    resp_pc,
  input  logic [EXC_W-1:0]   resp_exc,
  input  logic               pop_ready,
  output logic               pop_valid,
  output logic [INSTR_W-1:0] pop_instr,
  output logic [PC_W-1:0]    pop_pc,
  output logic [EXC_W-1:0]   pop_exc,
  output logic [CNT_W-1:0]   count,
  output logic               proto_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entryWidth(PC_W, INSTR_W, EXC_W);
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  logic [AW-1:0]      rdPtr, wrPtr;
  logic [CNT_W-1:0]   occupancy, outstanding, drop;
  logic [CNT_W-1:0]   outstandingNext, live;
  logic [CNT_W:0]     creditsUsed;
  logic               protoErr;
  logic               respLegal, respOrphan, push, popFire;
  logic [ENTRY_W-1:0] wrEntry, rdEntry;

  // A response with nothing outstanding is orphaned: flagged, never stored, never counted
  assign respLegal  = resp_valid & (outstanding != '0);
  assign respOrphan = resp_valid & (outstanding == '0);
  assign push       = respLegal & (drop == '0) & ~flush;
  assign pop_valid  = (occupancy != '0) & ~flush;
  assign popFire    = pop_valid & pop_ready;

  assign outstandingNext = outstanding + CNT_W'(req_issue) - CNT_W'(respLegal);

  // Every non-stale request in flight owns a slot, so a returning response always fits
  assign live        = outstanding - drop;
  assign creditsUsed = {1'b0, occupancy} + {1'b0, live};
  assign req_allow   = (creditsUsed < CREDIT_LIMIT) & ~flush & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop        <= '0;
      protoErr    <= 1'b0;
    end else begin
      outstanding <= outstandingNext;
      if (respOrphan) protoErr <= 1'b1;

      if (flush) begin
        rdPtr     <= '0;
        wrPtr     <= '0;
        occupancy <= '0;
        drop      <= outstandingNext;
      end else begin
        if (respLegal && drop != '0) drop <= drop - 1'b1;
        if (push)    wrPtr <= wrPtr + 1'b1;
        if (popFire) rdPtr <= rdPtr + 1'b1;
        case ({push, popFire})
          2'b10:   occupancy <= occupancy + 1'b1;
          2'b01:   occupancy <= occupancy - 1'b1;
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  assign wrEntry = {resp_pc, resp_instr, resp_exc};

  fifo_ram_2p #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) entryRam (
    .clk    (clk),
    .wrEn   (push),
    .wrAddr (wrPtr),
    .wrData (wrEntry),
    .rdAddr (rdPtr),
    .rdData (rdEntry)
  );

  assign {pop_pc, pop_instr, pop_exc} = rdEntry;
  assign count     = occupancy;
  assign proto_err = protoErr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed and randomized checks of inst_fetch_queue against a token-queue model
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, flush, req_issue, resp_valid, pop_ready;
  logic [31:0]      resp_instr, resp_pc;
  logic [7:0]       resp_exc;
  logic             req_allow, pop_valid, proto_err;
  logic [31:0]      pop_instr, pop_pc;
  logic [7:0]       pop_exc;
  logic [CNT_W-1:0] count;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_allow  (req_allow),
    .req_issue  (req_issue),
    .resp_valid (resp_valid),
    .resp_instr (resp_instr),
    .resp_pc    (resp_pc),
    .resp_exc   (resp_exc),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .pop_instr  (pop_instr),
    .pop_pc     (pop_pc),
    .pop_exc    (pop_exc),
    .count      (count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  // Model: one token per request in flight (stale after a flush), plus the queued entries
  bit          tokStale[$];
  fetchEntry_t mFifo[$];
  bit          mProtoErr;
  int          checks, failures, cyc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
    int          due;
  } memRsp_t;
  memRsp_t mem[$];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int liveTokens();
    int n = 0;
    foreach (tokStale[i]) if (!tokStale[i]) n++;
    return n;
  endfunction

  function automatic int staleTokens();
    return tokStale.size() - liveTokens();
  endfunction

  function automatic bit modelAllow(input bit fl);
    return ((mFifo.size() + liveTokens()) < DEPTH) && !fl;
  endfunction

  task automatic compareOutputs(input bit fl);
    bit expValid;
    expValid = (mFifo.size() != 0) && !fl;
    checkVal("req_allow", 64'(req_allow), 64'(modelAllow(fl)));
    checkVal("pop_valid", 64'(pop_valid), 64'(expValid));
    if (expValid) begin
      checkVal("pop_pc",    64'(pop_pc),    64'(mFifo[0].pc));
      checkVal("pop_instr", 64'(pop_instr), 64'(mFifo[0].instr));
      checkVal("pop_exc",   64'(pop_exc),   64'(mFifo[0].exc));
    end
    checkVal("count",     64'(count),     64'(mFifo.size()));
    checkVal("proto_err", 64'(proto_err), 64'(mProtoErr));
    checkVal("drop",      64'(dut.drop),  64'(staleTokens()));
  endtask

  task automatic modelUpdate(input bit fl, input bit iss, input bit rv,
                             input logic [31:0] pc, input logic [31:0] ins,
                             input logic [7:0] ex, input bit pr);
    fetchEntry_t e;
    bit s;
    if (!fl && mFifo.size() != 0 && pr) void'(mFifo.pop_front());
    if (rv) begin
      if (tokStale.size() == 0) mProtoErr = 1'b1;
      else begin
        s = tokStale.pop_front();
        if (!fl && !s) begin
          e.pc = pc; e.instr = ins; e.exc = ex;
          mFifo.push_back(e);
        end
      end
    end
    if (iss) tokStale.push_back(fl);
    if (fl) begin
      mFifo.delete();
      foreach (tokStale[i]) tokStale[i] = 1'b1;
    end
  endtask

  task automatic step(input bit fl, input bit iss, input bit rv,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic [7:0] ex, input bit pr);
    flush = fl; req_issue = iss; resp_valid = rv;
    resp_pc = pc; resp_instr = ins; resp_exc = ex; pop_ready = pr;
    #1;
    compareOutputs(fl);
    modelUpdate(fl, iss, rv, pc, ins, ex, pr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    flush = 0; req_issue = 0; resp_valid = 0; pop_ready = 0;
    resp_pc = '0; resp_instr = '0; resp_exc = '0;
    #1;
  endtask

  task automatic randomPhase(input int nCycles);
    bit fl, iss, rv, pr, room;
    logic [31:0] fetchPc, rpc, rins;
    logic [7:0] rex;
    memRsp_t m;
    fetchPc = 32'hBFC0_0000;
    for (int c = 0; c < nCycles; c++) begin
      fl   = ($urandom_range(0, 29) == 0);
      room = fl ? (tokStale.size() < DEPTH) : modelAllow(1'b0);
      iss  = room && ($urandom_range(0, 9) < 7);
      rv   = (mem.size() != 0) && (mem[0].due <= cyc) && ($urandom_range(0, 3) != 0);
      pr   = ($urandom_range(0, 9) < 7);
      rpc = '0; rins = '0; rex = '0;
      if (rv) begin
        m = mem.pop_front();
        rpc = m.pc; rins = m.instr; rex = m.exc;
      end
      if (iss) begin
        m.pc    = fetchPc;
        m.instr = $urandom;
        m.exc   = ($urandom_range(0, 7) == 0) ? 8'(1 << ADEL_IF) : 8'($urandom_range(0, 3));
        m.due   = cyc + $urandom_range(1, 3);
        mem.push_back(m);
        fetchPc = fetchPc + 32'd4;
      end
      if (fl) fetchPc = $urandom & 32'hFFFF_FFFC;
      step(fl, iss, rv, rpc, rins, rex, pr);
    end
    for (int c = 0; c < 40 && mem.size() != 0; c++) begin
      m = mem.pop_front();
      step(0, 0, 1, m.pc, m.instr, m.exc, 1);
    end
    for (int c = 0; c < DEPTH + 1; c++) step(0, 0, 0, '0, '0, '0, 1);
    idle();
    checkVal("rand_drained", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; mProtoErr = 0;
    rst = 1'b1;
    idle();
    #1;
    checkVal("rst_pop_valid", 64'(pop_valid), 64'd0);
    checkVal("rst_count",     64'(count),     64'd0);
    checkVal("rst_proto_err", 64'(proto_err), 64'd0);
    checkVal("rst_req_allow", 64'(req_allow), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fill with decode stalled, then drain in PC order
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'hBFC0_0000 + 32'(4 * i), 32'h2402_0000 + 32'(i), '0, 0);
    idle();
    checkVal("fill_count", 64'(count),     64'd4);
    checkVal("fill_allow", 64'(req_allow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      checkVal("drain_pc", 64'(pop_pc), 64'(32'hBFC0_0000 + 32'(4 * i)));
      step(0, 0, 0, '0, '0, '0, 1);
    end
    idle();
    checkVal("drain_count", 64'(count),     64'd0);
    checkVal("drain_valid", 64'(pop_valid), 64'd0);

    // Response latency: not visible in its own cycle, visible the next
    step(0, 1, 0, '0, '0, '0, 0);
    step(0, 0, 1, 32'hBFC0_0000, 32'h2402_0001, '0, 0);
    idle();
    checkVal("lat_valid", 64'(pop_valid), 64'd1);
    checkVal("lat_pc",    64'(pop_pc),    64'h0000_0000_BFC0_0000);
    checkVal("lat_instr", 64'(pop_instr), 64'h0000_0000_2402_0001);
    step(0, 0, 0, '0, '0, '0, 1);

    // Flush with two responses still in flight
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, '0, '0, 0);
    step(0, 0, 1, 32'h8000_0100, 32'h1111_1111, '0, 0);
    step(1, 0, 0, '0, '0, '0, 0);
    idle();
    checkVal("flush_drop",  64'(dut.drop), 64'd2);
    checkVal("flush_count", 64'(count),    64'd0);
    step(0, 0, 1, 32'h8000_0104, 32'h2222_2222, '0, 0);
    step(0, 0, 1, 32'h8000_0108, 32'h3333_3333, '0, 0);
    step(0, 1, 0, '0, '0, '0, 0);
    step(0, 0, 1, 32'hBFC0_0380, 32'h4000_6800, '0, 0);
    idle();
    checkVal("redirect_valid", 64'(pop_valid), 64'd1);
    checkVal("redirect_pc",    64'(pop_pc),    64'h0000_0000_BFC0_0380);
    step(0, 0, 0, '0, '0, '0, 1);

    // Flush in the same cycle as an issue and a response
    step(0, 1, 0, '0, '0, '0, 0);
    step(1, 1, 1, 32'hBFC0_0400, 32'h5555_5555, '0, 0);
    idle();
    checkVal("fsame_drop",  64'(dut.drop),  64'd1);
    checkVal("fsame_count", 64'(count),     64'd0);
    checkVal("fsame_allow", 64'(req_allow), 64'd1);
    step(0, 0, 1, 32'hBFC0_0404, 32'h6666_6666, '0, 0);

    // Ten-instruction stream through the ring with a one-cycle response delay
    for (int i = 0; i <= 10; i++) begin
      step(0, i < 10, i > 0, 32'hBFC0_1000 + 32'(4 * (i - 1)), 32'h1000_0000 + 32'(i - 1), '0, 1);
      checkVal("wrap_cnt_le2", 64'(count <= 2), 64'd1);
    end
    step(0, 0, 0, '0, '0, '0, 1);
    idle();
    checkVal("wrap_count", 64'(count),     64'd0);
    checkVal("wrap_proto", 64'(proto_err), 64'd0);

    randomPhase(3000);

    // Orphan response, then asynchronous reset mid-stream
    step(0, 0, 1, 32'hDEAD_0000, 32'hDEAD_BEEF, '0, 0);
    idle();
    checkVal("orphan_proto", 64'(proto_err), 64'd1);
    checkVal("orphan_count", 64'(count),     64'd0);
    step(0, 1, 0, '0, '0, '0, 0);
    step(0, 1, 0, '0, '0, '0, 0);
    step(0, 0, 1, 32'hBFC0_2000, 32'h7777_7777, '0, 0);
    idle();
    #1;
    rst = 1'b1;
    #1;
    checkVal("arst_req_allow", 64'(req_allow), 64'd0);
    checkVal("arst_pop_valid", 64'(pop_valid), 64'd0);
    checkVal("arst_count",     64'(count),     64'd0);
    checkVal("arst_proto_err", 64'(proto_err), 64'd0);
    tokStale.delete(); mFifo.delete(); mProtoErr = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, '0, '0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised instruction fetch queue between the instruction-memory response path and the decode-stage register. Tracks outstanding fetch requests with a credit counter, so every returned instruction is guaranteed a slot. Annuls stale in-flight responses after a branch or exception flush. Replaces the single-entry fetch path and its stallreq_from_if stall with a DEPTH-entry decoupling buffer that carries PC and fetch exception bits alongside each instruction.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
INSTR_W, 32, instruction width
PC_W, 32, PC width
EXC_W, 8, per-entry fetch exception vector width (bit EXC_W-1 = instruction address error)
CNT_W, $clog2(DEPTH+1), width of occupancy and outstanding counters (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  discard queue contents and all in-flight responses (branch redirect or exception)
req_allow  out  1  fetch unit may issue a new request this cycle
req_issue  in  1  request accepted by instruction memory this cycle
resp_valid  in  1  instruction response returned this cycle
resp_instr  in  INSTR_W  returned instruction
resp_pc  in  PC_W  PC of returned instruction
resp_exc  in  EXC_W  fetch exception bits for the response
pop_ready  in  1  decode accepts the head entry (~stallD)
pop_valid  out  1  head entry valid
pop_instr  out  INSTR_W  head instruction
pop_pc  out  PC_W  head PC
pop_exc  out  EXC_W  head exception bits
count  out  CNT_W  current occupancy
proto_err  out  1  sticky; set when resp_valid arrives with zero outstanding requests

Behaviour:
- Reset (asynchronous): read/write pointers 0, count 0, outstanding 0, drop 0, proto_err 0, pop_valid 0. Entry storage need not reset.
- pop outputs are driven from the head entry: pop_valid = (count != 0) & ~flush. Entry data is don't-care when pop_valid = 0.
- Pop fires on pop_valid & pop_ready. Head pointer advances by one and wraps modulo DEPTH.
- Response handling:
  - If resp_valid & drop != 0 & ~flush: response discarded, drop decrements.
  - If resp_valid & drop == 0 & ~flush: entry written at the tail, tail advances with wrap.
  - The written entry is visible on pop_valid the next cycle. There is no same-cycle bypass, so minimum response-to-decode latency is 1 cycle.
- outstanding_next = outstanding + req_issue - resp_valid. This applies in every cycle, including flush cycles.
- live = outstanding - drop. req_allow = ((count + live) < DEPTH) & ~flush. This guarantees no accepted response ever finds the queue full.
- Simultaneous push and pop at count == DEPTH cannot occur (credit invariant). A push and pop in the same cycle leaves count unchanged.
- Flush cycle:
  - Pointers and count cleared; any pop or response in that cycle is ignored.
  - drop_next = outstanding + req_issue - resp_valid, i.e. every request still in flight after this edge is marked stale.
  - A req_issue in the flush cycle is treated as stale.
- Back-to-back flushes: each one recomputes drop from outstanding. Drop never exceeds outstanding.
- resp_valid with outstanding == 0:
  - proto_err sets and holds until reset.
  - outstanding and drop saturate at 0.
  - The response is discarded.
- Counters never wrap. outstanding is bounded by DEPTH by construction; the verification engineer asserts this.

Decomposition:
- Shared pipeline package: EXC_W default, the exception-bit index constants (ADEL_IF bit = 7), and the entry struct {pc, instr, exc}.
- One sub-module, fifo_ram_2p: DEPTH x (PC_W+INSTR_W+EXC_W) storage, one write port and one asynchronous read port, no reset.
- Pointer, credit and drop logic stays in inst_fetch_queue.

Test Plan:
- Fill/drain: DEPTH=4, issue 4 requests, responses at pc 0xBFC00000..0xBFC0000C, pop_ready=0 -> req_allow=0 after 4th issue, count=4. Then pop_ready=1 -> 4 pops in PC order, count=0, pop_valid=0.
- Latency: single response at cycle N, pc 0xBFC00000, instr 0x24020001 -> pop_valid=1 with matching pc/instr at N+1, not at N.
- Flush with in-flight: 3 issued, 1 returned, flush while 2 outstanding -> count=0, drop=2. Next 2 responses are discarded. A subsequent request to 0xBFC00380 is the first entry popped.
- Flush same cycle as req_issue and resp_valid (outstanding=1 before) -> drop=1, queue empty, req_allow=0 during flush, 1 during the following cycle.
- Wrap-around: stream 10 instructions with pop_ready=1 and a 1-cycle response delay -> all 10 popped in order, count <= 2, no proto_err.
- Protocol error plus reset: resp_valid with nothing outstanding -> proto_err=1 and no entry written. Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
